// File: rtl/ssp_frame_pkg.sv
// rtl/ssp_frame_pkg.sv - shared FSM type, frame geometry and SSP register map
package ssp_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } ssp_frm_state_e;

    localparam int SSP_HDR_BITS   = 4;
    localparam int SSP_DATA_BITS  = 12;
    localparam int SSP_FRAME_BITS = SSP_HDR_BITS + SSP_DATA_BITS;

    localparam logic [2:0] UCR = 3'd0;
    localparam logic [2:0] USR = 3'd1;
    localparam logic [2:0] TDR = 3'd2;
    localparam logic [2:0] RDR = 3'd3;
    localparam logic [2:0] SPR = 3'd4;

endpackage

// File: rtl/ssp_frame_slave_if.sv
// rtl/ssp_frame_slave_if.sv - parallel SSP register bus between frame slave and ssp_uart
interface ssp_frame_slave_if;
    import ssp_frame_pkg::*;

    logic                     SSP_SSEL;
    logic [2:0]               SSP_RA;
    logic                     SSP_WnR;
    logic                     SSP_En;
    logic                     SSP_EOC;
    logic [SSP_DATA_BITS-1:0] SSP_DI;
    logic [SSP_DATA_BITS-1:0] SSP_DO;

    modport master (
        output SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI,
        input  SSP_DO
    );

    modport slave (
        input  SSP_SSEL, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI,
        output SSP_DO
    );

endinterface

// File: rtl/ssp_pin_sync.sv
// rtl/ssp_pin_sync.sv - synchroniser chains for the SPI pins plus SCK edge strobes
module ssp_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic nSSEL,
    input  logic SCK,
    input  logic MOSI,
    output logic ssel_n_s,
    output logic mosi_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] ssel_sr;
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sck_d;

    // Chains clear to 0 so a reset taken mid-frame never fakes an nSSEL falling edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ssel_sr <= '0;
            sck_sr  <= '0;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
        end else begin
            ssel_sr <= {ssel_sr[SYNC_STAGES-2:0], nSSEL};
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            sck_d   <= sck_sr[SYNC_STAGES-1];
        end
    end

    assign ssel_n_s = ssel_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign rise     = sck_sr[SYNC_STAGES-1] & ~sck_d;
    assign fall     = ~sck_sr[SYNC_STAGES-1] & sck_d;

endmodule

// File: rtl/ssp_frame_slave.sv
// rtl/ssp_frame_slave.sv - SPI mode-0 slave deserialising 16-bit frames onto the SSP bus
// Optional aborted-frame counter (Abort_Cnt/Abort_Clr) enabled by SSP_FRAME_ERR_CNT_EN.
module ssp_frame_slave
    import ssp_frame_pkg::*;
#(
    parameter int FRAME_W     = SSP_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic nSSEL,
    input  logic SCK,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE,
`ifdef SSP_FRAME_ERR_CNT_EN
    input  logic       Abort_Clr,
    output logic [7:0] Abort_Cnt,
`endif
    ssp_frame_slave_if.master bus
);

    logic ssel_n_s, mosi_s, rise, fall;

    ssp_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .nSSEL    (nSSEL),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .ssel_n_s (ssel_n_s),
        .mosi_s   (mosi_s),
        .rise     (rise),
        .fall     (fall)
    );

    ssp_frm_state_e           state;
    logic [4:0]               bcnt;
    logic [SSP_DATA_BITS-2:0] rx;
    logic [SSP_DATA_BITS-1:0] tx;
    logic [1:0]               ld_dly;
    logic                     ssel_q;
    logic                     last_bit;

    // rx keeps only the bits preceding the current one; the live bit comes from mosi_s.
    assign last_bit = rise && (bcnt == 5'(FRAME_W - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            bcnt         <= '0;
            rx           <= '0;
            tx           <= '0;
            ld_dly       <= '0;
            ssel_q       <= 1'b0;
            MISO         <= 1'b0;
            MISO_OE      <= 1'b0;
            bus.SSP_SSEL <= 1'b0;
            bus.SSP_RA   <= '0;
            bus.SSP_WnR  <= 1'b0;
            bus.SSP_En   <= 1'b0;
            bus.SSP_EOC  <= 1'b0;
            bus.SSP_DI   <= '0;
        end else begin
            ssel_q      <= ssel_n_s;
            bus.SSP_EOC <= 1'b0;
            unique case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ssel_q && !ssel_n_s) begin
                        state        <= HDR;
                        bcnt         <= '0;
                        rx           <= '0;
                        tx           <= '0;
                        ld_dly       <= '0;
                        bus.SSP_SSEL <= 1'b1;
                        MISO_OE      <= 1'b1;
                    end
                end
                HDR: begin
                    MISO <= 1'b0;
                    if (ssel_n_s) begin
                        state        <= IDLE;
                        bus.SSP_En   <= 1'b0;
                        bus.SSP_SSEL <= 1'b0;
                        MISO_OE      <= 1'b0;
                    end else if (rise) begin
                        rx   <= {rx[SSP_DATA_BITS-3:0], mosi_s};
                        bcnt <= bcnt + 5'd1;
                        if (bcnt == 5'(SSP_HDR_BITS - 1)) begin
                            bus.SSP_RA  <= rx[2:0];
                            bus.SSP_WnR <= mosi_s;
                            bus.SSP_En  <= 1'b1;
                            ld_dly      <= 2'd2;
                            state       <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Give ssp_uart two cycles after SSP_En before SSP_DO is captured.
                    if (ld_dly != 2'd0) begin
                        ld_dly <= ld_dly - 2'd1;
                        if (ld_dly == 2'd1) tx <= bus.SSP_DO;
                    end else if (fall) begin
                        MISO <= tx[SSP_DATA_BITS-1];
                        tx   <= {tx[SSP_DATA_BITS-2:0], 1'b0};
                    end
                    // The final bit wins over a simultaneous nSSEL release.
                    if (last_bit) begin
                        bus.SSP_DI  <= {rx, mosi_s};
                        bus.SSP_EOC <= 1'b1;
                        MISO        <= 1'b0;
                        state       <= DONE;
                    end else if (ssel_n_s) begin
                        state        <= IDLE;
                        MISO         <= 1'b0;
                        bus.SSP_En   <= 1'b0;
                        bus.SSP_SSEL <= 1'b0;
                        MISO_OE      <= 1'b0;
                    end else if (rise) begin
                        rx   <= {rx[SSP_DATA_BITS-3:0], mosi_s};
                        bcnt <= bcnt + 5'd1;
                    end
                end
                DONE: begin
                    MISO <= 1'b0;
                    if (ssel_n_s) begin
                        state        <= IDLE;
                        bus.SSP_En   <= 1'b0;
                        bus.SSP_SSEL <= 1'b0;
                        MISO_OE      <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef SSP_FRAME_ERR_CNT_EN
    logic abort_ev;

    assign abort_ev = ((state == HDR) || (state == DATA)) && ssel_n_s &&
                      !((state == DATA) && last_bit);

    always_ff @(posedge Clk) begin
        if (Rst || Abort_Clr) begin
            Abort_Cnt <= 8'h00;
        end else if (abort_ev && (Abort_Cnt != 8'hFF)) begin
            Abort_Cnt <= Abort_Cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_ssp_frame_slave.sv
// tb/tb_ssp_frame_slave.sv - self-checking bench for ssp_frame_slave
module tb_ssp_frame_slave;
    import ssp_frame_pkg::*;

    logic clk = 1'b0;
    logic rst, nssel, sck, mosi, abort_clr;
    wire  miso, miso_oe;
`ifdef SSP_FRAME_ERR_CNT_EN
    wire [7:0] abort_cnt;
`endif

    ssp_frame_slave_if bus ();

    ssp_frame_slave #(.FRAME_W(16), .SYNC_STAGES(2)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .nSSEL     (nssel),
        .SCK       (sck),
        .MOSI      (mosi),
        .MISO      (miso),
        .MISO_OE   (miso_oe),
`ifdef SSP_FRAME_ERR_CNT_EN
        .Abort_Clr (abort_clr),
        .Abort_Cnt (abort_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    int          eoc_hi = 0;
    int          en_rises = 0;
    logic        en_prev = 1'b0;
    time         en_time = 0;
    time         eoc_time = 0;
    logic [11:0] eoc_di = '0;

    always @(negedge clk) begin
        if (bus.SSP_En === 1'b1 && !en_prev) begin
            en_rises <= en_rises + 1;
            en_time  <= $time;
        end
        en_prev <= (bus.SSP_En === 1'b1);
        if (bus.SSP_EOC === 1'b1) begin
            eoc_hi   <= eoc_hi + 1;
            eoc_time <= $time;
            eoc_di   <= bus.SSP_DI;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // One SPI mode-0 frame; bits past the 16th are sent as 1s to show they are ignored.
    task automatic run_frame(input logic [15:0] word, input int nbits, input int gap_ns,
                             output logic [11:0] miso_w, output time t4, output time t16);
        miso_w = '0;
        t4 = 0;
        t16 = 0;
        nssel = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b1;
            #30 sck = 1'b1;
            if (i == 3) t4 = $time;
            if (i == 15) t16 = $time;
            if (i >= 4 && i < 16) miso_w[15-i] = miso;
            #30 sck = 1'b0;
        end
        #30 nssel = 1'b1;
        #(gap_ns);
    endtask

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [11:0] do_val;
        int          exp_eoc;
        logic [11:0] exp_di;
        logic [2:0]  exp_ra;
        logic        exp_wnr;
    } vec_t;

    vec_t        vecs[6];
    logic [11:0] mw, m_di;
    logic [2:0]  m_ra;
    logic        m_wnr;
    int          m_abort = 0;
    int          e0, h0, r0;
    time         t4, t16;

    initial begin
        vecs[0] = '{16'h15A3, 16, 12'h0F0, 1, 12'h5A3, UCR, 1'b1};
        vecs[1] = '{16'h2000, 16, 12'hC3C, 1, 12'h000, USR, 1'b0};
        vecs[2] = '{16'hF123, 20, 12'hABC, 1, 12'h123, 3'd7, 1'b1};
        vecs[3] = '{16'h4FFF,  9, 12'h555, 0, 12'h123, TDR, 1'b0};
        vecs[4] = '{16'h8000, 16, 12'h001, 1, 12'h000, SPR, 1'b0};
        vecs[5] = '{16'hFFFF,  3, 12'h777, 0, 12'h000, SPR, 1'b0};

        rst = 1'b1; nssel = 1'b1; sck = 1'b0; mosi = 1'b0; abort_clr = 1'b0;
        bus.SSP_DO = '0;
        #30;
        chk("rst_miso", 32'(miso), 0);
        chk("rst_miso_oe", 32'(miso_oe), 0);
        chk("rst_ssel", 32'(bus.SSP_SSEL), 0);
        chk("rst_ra", 32'(bus.SSP_RA), 0);
        chk("rst_wnr", 32'(bus.SSP_WnR), 0);
        chk("rst_en", 32'(bus.SSP_En), 0);
        chk("rst_eoc", 32'(bus.SSP_EOC), 0);
        chk("rst_di", 32'(bus.SSP_DI), 0);
        #10 rst = 1'b0;
        #60;

        for (int k = 0; k < 6; k++) begin
            bus.SSP_DO = vecs[k].do_val;
            e0 = eoc_hi;
            r0 = en_rises;
            run_frame(vecs[k].word, vecs[k].nbits, 100, mw, t4, t16);
            chk($sformatf("vec%0d_eoc_cycles", k), 32'(eoc_hi - e0), 32'(vecs[k].exp_eoc));
            chk($sformatf("vec%0d_en_rises", k), 32'(en_rises - r0), (vecs[k].nbits >= 4) ? 1 : 0);
            chk($sformatf("vec%0d_di", k), 32'(bus.SSP_DI), 32'(vecs[k].exp_di));
            chk($sformatf("vec%0d_ra", k), 32'(bus.SSP_RA), 32'(vecs[k].exp_ra));
            chk($sformatf("vec%0d_wnr", k), 32'(bus.SSP_WnR), 32'(vecs[k].exp_wnr));
            chk($sformatf("vec%0d_idle", k), {28'd0, bus.SSP_En, bus.SSP_SSEL, miso_oe, miso}, 0);
            if (vecs[k].exp_eoc == 1) begin
                chk($sformatf("vec%0d_miso", k), 32'(mw), 32'(vecs[k].do_val));
                chk($sformatf("vec%0d_eoc_di", k), 32'(eoc_di), 32'(vecs[k].exp_di));
            end else begin
                m_abort++;
            end
            // Strobes act on the third Clk edge after a pin edge; outputs register there.
            if (k == 0) begin
                chk("en_latency_ns", 32'(en_time - t4), 30);
                chk("eoc_latency_ns", 32'(eoc_time - t16), 30);
            end
        end

        e0 = eoc_hi;
        bus.SSP_DO = 12'h0AA;
        run_frame(16'h3ABC, 16, 30, mw, t4, t16);
        chk("b2b_first_di", 32'(bus.SSP_DI), 32'h0ABC);
        chk("b2b_first_ra", 32'(bus.SSP_RA), 1);
        run_frame(16'h1456, 16, 100, mw, t4, t16);
        chk("b2b_second_di", 32'(bus.SSP_DI), 32'h456);
        chk("b2b_eoc_cycles", 32'(eoc_hi - e0), 2);
        chk("b2b_second_miso", 32'(mw), 32'h0AA);
        m_di = 12'h456; m_ra = 3'd0; m_wnr = 1'b1;

        for (int k = 0; k < 24; k++) begin
            logic [15:0] w;
            logic [11:0] dv;
            int          nb, gap;
            w   = 16'($urandom);
            dv  = 12'($urandom);
            nb  = ($urandom_range(0, 3) != 0) ? $urandom_range(16, 20) : $urandom_range(1, 15);
            gap = 10 * $urandom_range(6, 10);
            if (nb >= 4) begin
                m_ra  = w[15:13];
                m_wnr = w[12];
            end
            if (nb >= 16) m_di = w[11:0];
            else m_abort = (m_abort == 255) ? 255 : m_abort + 1;
            bus.SSP_DO = dv;
            e0 = eoc_hi;
            run_frame(w, nb, gap, mw, t4, t16);
            chk($sformatf("rnd%0d_eoc_cycles", k), 32'(eoc_hi - e0), (nb >= 16) ? 1 : 0);
            chk($sformatf("rnd%0d_di", k), 32'(bus.SSP_DI), 32'(m_di));
            chk($sformatf("rnd%0d_hdr", k), {28'd0, m_ra, m_wnr} ^ {28'd0, bus.SSP_RA, bus.SSP_WnR}, 0);
            chk($sformatf("rnd%0d_idle", k), {28'd0, bus.SSP_En, bus.SSP_SSEL, miso_oe, miso}, 0);
            if (nb >= 16) chk($sformatf("rnd%0d_miso", k), 32'(mw), 32'(dv));
        end

`ifdef SSP_FRAME_ERR_CNT_EN
        chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
        #10 abort_clr = 1'b1;
        #10 abort_clr = 1'b0;
        #10;
        chk("abort_cnt_clr", 32'(abort_cnt), 0);
`endif

        // Reset in the middle of a frame: the tail must be ignored until nSSEL goes high.
        bus.SSP_DO = 12'h3C3;
        nssel = 1'b0;
        #60;
        for (int i = 0; i < 7; i++) begin
            mosi = 1'b1;
            #30 sck = 1'b1;
            #30 sck = 1'b0;
        end
        rst = 1'b1;
        #20 rst = 1'b0;
        #10;
        chk("midrst_outputs", {20'd0, bus.SSP_DI},
            {31'd0, 1'b0} | {19'd0, bus.SSP_RA, bus.SSP_WnR, bus.SSP_En, bus.SSP_EOC, bus.SSP_SSEL, miso_oe, miso, 5'd0});
        chk("midrst_di", 32'(bus.SSP_DI), 0);
        chk("midrst_ctrl", {25'd0, bus.SSP_RA, bus.SSP_WnR, bus.SSP_En, bus.SSP_SSEL, miso_oe, miso}, 0);
        e0 = eoc_hi;
        r0 = en_rises;
        for (int i = 7; i < 16; i++) begin
            mosi = 1'b1;
            #30 sck = 1'b1;
            #30 sck = 1'b0;
        end
        #30 nssel = 1'b1;
        #60;
        chk("midrst_tail_eoc", 32'(eoc_hi - e0), 0);
        chk("midrst_tail_en", 32'(en_rises - r0), 0);
        chk("midrst_tail_di", 32'(bus.SSP_DI), 0);
`ifdef SSP_FRAME_ERR_CNT_EN
        chk("midrst_abort_cnt", 32'(abort_cnt), 0);
`endif
        run_frame(16'h1777, 16, 100, mw, t4, t16);
        chk("post_rst_eoc", 32'(eoc_hi - e0), 1);
        chk("post_rst_di", 32'(bus.SSP_DI), 32'h777);
        chk("post_rst_miso", 32'(mw), 32'h3C3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ssp_frame_slave.md
# ssp_frame_slave

SPI-mode-0 slave front end that sits directly upstream of `ssp_uart`. It oversamples the external SPI pins in the `Clk` domain and deserialises 16-bit frames into the parallel SSP register bus (`SSP_RA`, `SSP_WnR`, `SSP_En`, `SSP_EOC`, `SSP_DI`) that `ssp_uart` consumes. It also returns `SSP_DO` on MISO for reads, so `ssp_uart` registers become reachable from an off-chip SPI master.

## Interface
Parameters:
- `FRAME_W`, 16: bits per frame; fixed as 3 RA + 1 WnR + 12 data.
- `SYNC_STAGES`, 2: synchroniser depth on `nSSEL`, `SCK` and `MOSI`.

Ports:
- `Clk`  in  1  system clock; the only clock.
- `Rst`  in  1  synchronous, active-high reset.
- `nSSEL`  in  1  external slave select, active low, asynchronous.
- `SCK`  in  1  external SPI clock, asynchronous.
- `MOSI`  in  1  external serial data in, MSB first.
- `MISO`  out  1  serial data out.
- `MISO_OE`  out  1  MISO output enable; high only while a frame is selected.
- `SSP_SSEL`  out  1  frame active (synchronised, inverted `nSSEL`).
- `SSP_RA`  out  3  register address.
- `SSP_WnR`  out  1  1 = write, 0 = read.
- `SSP_En`  out  1  header valid; high from header completion to frame end.
- `SSP_EOC`  out  1  one-`Clk` end-of-cycle pulse.
- `SSP_DI`  out  12  write data to `ssp_uart`.
- `SSP_DO`  in  12  read data from `ssp_uart`.

## Operation
- Inputs pass through a `SYNC_STAGES` flop chain. Edge detect on the synchronised `SCK` produces the one-cycle strobes `rise` and `fall`.
- Bit counter `bcnt[4:0]` counts `rise` events within the frame. Shift-in register `rx[15:0]` samples MOSI on `rise`. Shift-out register `tx[11:0]` updates MISO on `fall`.
- FSM states:
  - **IDLE**: outputs quiescent. Synchronised `nSSEL` falls → HDR, clear `bcnt`, `SSP_SSEL`=1, `MISO_OE`=1.
  - **HDR**: bits 0–3. On the 4th `rise`, latch `SSP_RA`=rx[3:1], `SSP_WnR`=rx[0], assert `SSP_En`, go to DATA.
  - **DATA**: bits 4–15. Two `Clk` cycles after `SSP_En` rises, load `tx` from `SSP_DO`. On the 16th `rise`, `SSP_DI`=rx[11:0], pulse `SSP_EOC` for one `Clk`, go to DONE.
  - **DONE**: ignore further `SCK` edges. `nSSEL` rises → IDLE.
  - `nSSEL` rises in HDR or DATA (abort) → IDLE:
    - `SSP_EOC` is not pulsed.
    - `SSP_En`, `SSP_SSEL` and `MISO_OE` drop the next cycle.
    - `SSP_DI` holds its previous value.
- `SSP_DO` is loaded for writes as well; the master ignores MISO in that case.
- MISO behaviour:
  - Driven 0 during HDR.
  - On the `fall` following bit 3, drives `tx[11]`; each later `fall` shifts left.
  - Driven 0 in DONE and IDLE.
- `SSP_EOC` and `nSSEL` deassertion on the same cycle: EOC still pulses, then IDLE.
- `Rst` asserted mid-frame: returns to IDLE with reset values. The remainder of the frame is ignored until `nSSEL` has been seen high.

## Timing
- Reset values: `MISO`=0, `MISO_OE`=0, `SSP_SSEL`=0, `SSP_RA`=0, `SSP_WnR`=0, `SSP_En`=0, `SSP_EOC`=0, `SSP_DI`=12'h000. Counter and shift registers are also 0.
- Pin-to-strobe latency: `SYNC_STAGES`+1 `Clk` from a pin edge to `rise`/`fall`.
- `SSP_En` rises 1 `Clk` after the 4th `rise`. `SSP_EOC` pulses 1 `Clk` after the 16th `rise`.
- `SSP_DO` must be stable by 2 `Clk` after `SSP_En` rises.
- SCK high and low phases must each be ≥ 3 `Clk` periods, i.e. `SCK` ≤ `Clk`/6. The 10 ns `Clk` with 30 ns half-period `SCK` meets this.
- `nSSEL` setup to the first `SCK` rise must be ≥ 3 `Clk`.

## Configuration
- `SSP_FRAME_ERR_CNT_EN` defined:
  - Adds output `Abort_Cnt[7:0]` and input `Abort_Clr`.
  - Counter increments on each aborted frame and saturates at 8'hFF.
  - `Abort_Clr` (or `Rst`) zeroes it; clear wins over a simultaneous increment.
- Undefined: ports and counter absent; aborts are silent.

## Structure
- Shared package `ssp_frame_pkg`:
  - FSM enum `ssp_frm_state_e` (IDLE, HDR, DATA, DONE).
  - Constants: `SSP_HDR_BITS`=4, `SSP_DATA_BITS`=12, `SSP_FRAME_BITS`=16.
  - Register address localparams UCR=0, USR=1, TDR=2, RDR=3, SPR=4, shared with `ssp_uart` tests.
- One sub-module: `ssp_pin_sync`, the synchroniser chain plus `SCK` edge detector (outputs `ssel_n_s`, `mosi_s`, `rise`, `fall`).

## Test plan
- Write frame RA=3'b000, WnR=1, data=12'h5A3 → `SSP_En` at the 4th rise, `SSP_EOC` a single pulse, `SSP_DI`=12'h5A3, `SSP_RA`=0; `ssp_uart` UCR reads back 12'h5A3.
- Read frame RA=3'b001 with `SSP_DO`=12'hC3C → MISO bits 4–15 sampled by the bench equal 12'hC3C, MSB first; `SSP_WnR`=0.
- Abort: `nSSEL` raised after 9 bits → no `SSP_EOC`, `SSP_DI` unchanged, FSM back in IDLE; with `SSP_FRAME_ERR_CNT_EN`, `Abort_Cnt`=1.
- Extra clocks: 20 `SCK` rises in one frame → exactly one `SSP_EOC`; data taken from bits 4–15 only.
- `Rst` pulsed at bit 7 → all outputs return to reset values; the rest of that frame produces no `SSP_En`/`SSP_EOC`; the next full frame completes normally.
- Back-to-back frames with `nSSEL` high for 3 `Clk` between them → two `SSP_EOC` pulses, both with correct `SSP_DI`.
